// File: rtl/audio_ram_pkg.sv
// Shared constants and types for the audio RAM arbiter and its read-return pipeline.
package audio_ram_pkg;
    localparam int ADDR_W = 12;
    localparam int DATA_W = 256;
    localparam int BE_W   = 32;
    localparam int DEPTH  = 4000;

    typedef enum logic {
        REQ_CPU = 1'b0,
        REQ_DMA = 1'b1
    } req_id_t;

    typedef struct packed {
        logic    valid;
        req_id_t id;
        logic    oor;
    } rd_tag_t;
endpackage

// File: rtl/audio_ram_rd_pipe.sv
// Two-stage read-return pipeline: tags follow the RAM access, stage 2 captures the
// RAM output into the tagged requester's read-data register.
module audio_ram_rd_pipe
    import audio_ram_pkg::*;
#(
    parameter int DATA_W = audio_ram_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  rd_tag_t           issue_tag,
    input  logic [DATA_W-1:0] ram_readdata,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid
);
    rd_tag_t           tag_q;
    logic              rdv0_q, rdv1_q;
    logic [DATA_W-1:0] rd0_q, rd1_q;
    logic              ret0, ret1;
    logic [DATA_W-1:0] ret_data;

    assign ret0     = tag_q.valid && (tag_q.id == REQ_CPU);
    assign ret1     = tag_q.valid && (tag_q.id == REQ_DMA);
    assign ret_data = tag_q.oor ? '0 : ram_readdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            tag_q  <= '0;
            rdv0_q <= 1'b0;
            rdv1_q <= 1'b0;
            rd0_q  <= '0;
            rd1_q  <= '0;
        end else begin
            tag_q  <= issue_tag;
            rdv0_q <= ret0;
            rdv1_q <= ret1;
            if (ret0) rd0_q <= ret_data;
            if (ret1) rd1_q <= ret_data;
        end
    end

    // Outputs read as idle for the whole reset cycle, not only after the edge.
    assign m0_readdatavalid = rdv0_q & ~reset;
    assign m1_readdatavalid = rdv1_q & ~reset;
    assign m0_readdata      = reset ? '0 : rd0_q;
    assign m1_readdata      = reset ? '0 : rd1_q;
endmodule

// File: rtl/audio_ram_arbiter.sv
// Round-robin arbiter sharing the single-port audio RAM between the Nios data path
// (requester 0) and the sample DMA (requester 1), with range checking.
module audio_ram_arbiter
    import audio_ram_pkg::*;
#(
    parameter int ADDR_W = audio_ram_pkg::ADDR_W,
    parameter int DATA_W = audio_ram_pkg::DATA_W,
    parameter int BE_W   = audio_ram_pkg::BE_W,
    parameter int DEPTH  = audio_ram_pkg::DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic [BE_W-1:0]   m0_byteenable,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic [BE_W-1:0]   m1_byteenable,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,
    output logic [ADDR_W-1:0] ram_address,
    output logic [BE_W-1:0]   ram_byteenable,
    output logic [DATA_W-1:0] ram_writedata,
    output logic              ram_chipselect,
    output logic              ram_write,
    output logic              ram_debugaccess,
    output logic              ram_clken,
    input  logic [DATA_W-1:0] ram_readdata,
    output logic              err_oor,
    output logic              err_rw
);
    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

    logic    ready_q, active;
    logic    req0, req1, grant, gnt_read, gnt_write, gnt_oor, wr_en;
    req_id_t last_grant, gnt_id;
    rd_tag_t issue_tag;

    // ready_q holds the port idle for one extra cycle after reset is released.
    always_ff @(posedge clk) begin
        if (reset) begin
            ready_q    <= 1'b0;
            last_grant <= REQ_DMA;
            err_oor    <= 1'b0;
            err_rw     <= 1'b0;
        end else begin
            ready_q <= 1'b1;
            err_oor <= grant & gnt_oor;
            err_rw  <= grant & gnt_read & gnt_write;
            if (grant) last_grant <= gnt_id;
        end
    end

    always_comb begin
        active = ready_q & ~reset;
        req0   = m0_read | m0_write;
        req1   = m1_read | m1_write;
        grant  = active & (req0 | req1);
        gnt_id = REQ_CPU;
        if (req0 && req1)
            gnt_id = (last_grant == REQ_CPU) ? REQ_DMA : REQ_CPU;
        else if (req1)
            gnt_id = REQ_DMA;

        if (gnt_id == REQ_DMA) begin
            ram_address    = m1_address;
            ram_byteenable = m1_byteenable;
            ram_writedata  = m1_writedata;
            gnt_read       = m1_read;
            gnt_write      = m1_write;
        end else begin
            ram_address    = m0_address;
            ram_byteenable = m0_byteenable;
            ram_writedata  = m0_writedata;
            gnt_read       = m0_read;
            gnt_write      = m0_write;
        end
        gnt_oor = {1'b0, ram_address} >= DEPTH_LIM;

        // A combined read+write is a write; it issues no read tag.
        wr_en           = grant & gnt_write & ~gnt_oor;
        ram_chipselect  = wr_en;
        ram_write       = wr_en;
        ram_debugaccess = wr_en;
        ram_clken       = active;

        m0_waitrequest = ~active | (req0 & ~(grant & (gnt_id == REQ_CPU)));
        m1_waitrequest = ~active | (req1 & ~(grant & (gnt_id == REQ_DMA)));

        issue_tag.valid = grant & gnt_read & ~gnt_write;
        issue_tag.id    = gnt_id;
        issue_tag.oor   = gnt_oor;
    end

    audio_ram_rd_pipe #(.DATA_W(DATA_W)) u_rd_pipe (
        .clk              (clk),
        .reset            (reset),
        .issue_tag        (issue_tag),
        .ram_readdata     (ram_readdata),
        .m0_readdata      (m0_readdata),
        .m0_readdatavalid (m0_readdatavalid),
        .m1_readdata      (m1_readdata),
        .m1_readdatavalid (m1_readdatavalid)
    );
endmodule

// File: tb/tb_audio_ram_arbiter.sv
// Directed bench for audio_ram_arbiter with a behavioural single-port RAM model.
module tb_audio_ram_arbiter;
    localparam int ADDR_W = 12;
    localparam int DATA_W = 256;
    localparam int BE_W   = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic [ADDR_W-1:0] m0_address, m1_address;
    logic [BE_W-1:0]   m0_byteenable, m1_byteenable;
    logic              m0_read, m0_write, m1_read, m1_write;
    logic [DATA_W-1:0] m0_writedata, m1_writedata;
    logic              m0_waitrequest, m1_waitrequest;
    logic [DATA_W-1:0] m0_readdata, m1_readdata;
    logic              m0_readdatavalid, m1_readdatavalid;
    logic [ADDR_W-1:0] ram_address;
    logic [BE_W-1:0]   ram_byteenable;
    logic [DATA_W-1:0] ram_writedata, ram_readdata;
    logic              ram_chipselect, ram_write, ram_debugaccess, ram_clken;
    logic              err_oor, err_rw;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    audio_ram_arbiter dut (
        .clk(clk), .reset(reset),
        .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
        .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
        .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
        .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
        .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
        .ram_address(ram_address), .ram_byteenable(ram_byteenable),
        .ram_writedata(ram_writedata), .ram_chipselect(ram_chipselect),
        .ram_write(ram_write), .ram_debugaccess(ram_debugaccess), .ram_clken(ram_clken),
        .ram_readdata(ram_readdata), .err_oor(err_oor), .err_rw(err_rw)
    );

    function automatic logic [DATA_W-1:0] pat(input int a);
        logic [DATA_W-1:0] r;
        for (int j = 0; j < 8; j++) r[j*32 +: 32] = 32'hC0DE_0000 ^ 32'(a * 8 + j);
        return r;
    endfunction

    // RAM model: preloaded with pat() during reset, byte-lane writes, output valid next cycle.
    logic [DATA_W-1:0] mem [0:4095];
    logic [ADDR_W-1:0] ram_addr_q;
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4096; i++) mem[i] <= pat(i);
        end else if (ram_clken && ram_chipselect && ram_write && ram_debugaccess) begin
            for (int j = 0; j < BE_W; j++)
                if (ram_byteenable[j]) mem[ram_address][j*8 +: 8] <= ram_writedata[j*8 +: 8];
        end
        ram_addr_q <= ram_address;
    end
    assign ram_readdata = mem[ram_addr_q];

    task automatic check_val(input string tag, input logic [DATA_W-1:0] got,
                             input logic [DATA_W-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
    endtask

    logic [DATA_W-1:0] exp_d;
    logic [DATA_W-1:0] wd;

    initial begin
        reset = 1;
        idle_inputs();
        m0_address = '0; m1_address = '0;
        m0_byteenable = '1; m1_byteenable = '1;
        m0_writedata = '0; m1_writedata = '0;

        // Reset and the cycle after it
        repeat (3) next_cyc();
        check_val("rst_wait0", m0_waitrequest, 1);
        check_val("rst_clken", ram_clken, 0);
        reset = 0;
        #1;
        check_val("post_wait0", m0_waitrequest, 1);
        check_val("post_wait1", m1_waitrequest, 1);
        check_val("post_clken", ram_clken, 0);
        check_val("post_rdv0", m0_readdatavalid, 0);
        check_val("post_rd0", m0_readdata, 0);
        check_val("post_err", {err_oor, err_rw}, 0);
        next_cyc();
        check_val("run_clken", ram_clken, 1);
        check_val("idle_wait", {m0_waitrequest, m1_waitrequest}, 0);

        // Both read continuously: grants alternate starting with requester 0
        for (int k = 0; k < 10; k++) begin
            if (k < 8) begin
                m0_read = 1; m0_address = 12'(32'h100 + (k + 1) / 2);
                m1_read = 1; m1_address = 12'(32'h200 + k / 2);
            end else begin
                idle_inputs();
            end
            #1;
            if (k < 8) begin
                check_val($sformatf("rr_wait0_%0d", k), m0_waitrequest, (k % 2) != 0);
                check_val($sformatf("rr_wait1_%0d", k), m1_waitrequest, (k % 2) == 0);
            end
            if (k >= 2) begin
                if (((k - 2) % 2) == 0) begin
                    check_val($sformatf("rr_rdv_%0d", k), {m0_readdatavalid, m1_readdatavalid}, 2'b10);
                    check_val($sformatf("rr_d0_%0d", k), m0_readdata, pat(32'h100 + (k - 2) / 2));
                end else begin
                    check_val($sformatf("rr_rdv_%0d", k), {m0_readdatavalid, m1_readdatavalid}, 2'b01);
                    check_val($sformatf("rr_d1_%0d", k), m1_readdata, pat(32'h200 + (k - 2) / 2));
                end
            end
            next_cyc();
        end

        // Single read by requester 0 at 0x010
        m0_read = 1; m0_address = 12'h010;
        #1;
        check_val("s_wait0", m0_waitrequest, 0);
        check_val("s_addr", ram_address, 12'h010);
        next_cyc();
        idle_inputs();
        #1;
        check_val("s_rdv_t1", m0_readdatavalid, 0);
        next_cyc();
        check_val("s_rdv_t2", {m0_readdatavalid, m1_readdatavalid}, 2'b10);
        check_val("s_data", m0_readdata, pat(32'h010));
        next_cyc();
        check_val("s_rdv_t3", m0_readdatavalid, 0);

        // Partial write by requester 1, read back by requester 0 next cycle
        m1_write = 1; m1_address = 12'd5; m1_byteenable = 32'h0000_000F; m1_writedata = '1;
        #1;
        check_val("pw_wait1", m1_waitrequest, 0);
        check_val("pw_qual", {ram_chipselect, ram_write, ram_debugaccess}, 3'b111);
        next_cyc();
        m1_write = 0;
        m0_read = 1; m0_address = 12'd5;
        #1;
        check_val("pw_rd_wait0", m0_waitrequest, 0);
        next_cyc();
        idle_inputs();
        next_cyc();
        exp_d = pat(5);
        exp_d[31:0] = 32'hFFFF_FFFF;
        check_val("pw_rdv", m0_readdatavalid, 1);
        check_val("pw_data", m0_readdata, exp_d);

        // Out-of-range write then read
        m0_write = 1; m0_address = 12'd4000; m0_writedata = '1; m0_byteenable = '1;
        #1;
        check_val("oor_wr_wait", m0_waitrequest, 0);
        check_val("oor_ram_write", ram_write, 0);
        next_cyc();
        check_val("oor_err_w", err_oor, 1);
        m0_write = 0; m0_read = 1; m0_address = 12'd4095;
        #1;
        check_val("oor_rd_wait", m0_waitrequest, 0);
        next_cyc();
        idle_inputs();
        #1;
        check_val("oor_err_r", err_oor, 1);
        check_val("oor_rdv_early", m0_readdatavalid, 0);
        next_cyc();
        check_val("oor_rdv", m0_readdatavalid, 1);
        check_val("oor_data", m0_readdata, 0);
        check_val("oor_err_clr", err_oor, 0);

        // Read and write together: treated as a write
        wd = pat(32'h777) ^ {DATA_W{1'b1}};
        m0_read = 1; m0_write = 1; m0_address = 12'd7; m0_writedata = wd;
        #1;
        check_val("rw_ram_write", ram_write, 1);
        check_val("rw_wait", m0_waitrequest, 0);
        next_cyc();
        idle_inputs();
        #1;
        check_val("rw_err", {err_rw, err_oor}, 2'b10);
        next_cyc();
        check_val("rw_no_rdv", m0_readdatavalid, 0);
        m0_read = 1; m0_address = 12'd7;
        next_cyc();
        idle_inputs();
        next_cyc();
        check_val("rw_rb_rdv", m0_readdatavalid, 1);
        check_val("rw_rb_data", m0_readdata, wd);

        // Reset right after a granted read discards it; tie then goes to requester 0
        m0_read = 1; m0_address = 12'h010;
        #1;
        check_val("mr_wait0", m0_waitrequest, 0);
        next_cyc();
        idle_inputs();
        reset = 1;
        #1;
        check_val("mr_rst_wait", {m0_waitrequest, m1_waitrequest}, 2'b11);
        check_val("mr_rst_clken", ram_clken, 0);
        next_cyc();
        reset = 0;
        m0_read = 1; m1_read = 1; m0_address = 12'h020; m1_address = 12'h030;
        #1;
        check_val("mr_rdv", {m0_readdatavalid, m1_readdatavalid}, 0);
        check_val("mr_rd0", m0_readdata, 0);
        check_val("mr_post_wait", {m0_waitrequest, m1_waitrequest}, 2'b11);
        check_val("mr_post_qual", {ram_chipselect, ram_write, ram_debugaccess, ram_clken}, 0);
        next_cyc();
        check_val("mr_tie1", {m0_waitrequest, m1_waitrequest}, 2'b01);
        next_cyc();
        check_val("mr_tie2", {m0_waitrequest, m1_waitrequest}, 2'b10);
        idle_inputs();
        next_cyc();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
